core_bank_sequencer: RTL and testbench

- Sits between a bank of N parallel rede_taylor cores and the single shared output path of the multicore top.
- Releases per-core resets one at a time on a programmable stagger, with soft restart.
- Arbitrates core outputs with fixed-priority or round-robin selection, registers the winner, and counts output collisions.
- Cores are instantiated by the parent, which also broadcasts io_in to them.

---
 rtl/core_bank_pkg.sv | 30 +++
 rtl/core_bank_arbiter.sv | 56 +++++
 rtl/core_bank_sequencer.sv | 155 +++++++++++++++
 tb/tb_core_bank_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bank_pkg.sv
// Shared types and helpers for the core bank sequencer and its arbiter.
package core_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_e;

    localparam int COLL_CNT_W  = 16;

    // Widest packed bus and widest field that extract_slice can handle.
    localparam int BUS_MAX_W   = 8192;
    localparam int SLICE_MAX_W = 32;

    // Return field k of width w from a packed bus (field 0 in the LSBs),
    // zero-extended to SLICE_MAX_W bits.
    function automatic logic [SLICE_MAX_W-1:0] extract_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [BUS_MAX_W-1:0]   shifted;
        logic [SLICE_MAX_W-1:0] mask;
        shifted = bus >> (k * w);
        mask    = (w >= SLICE_MAX_W) ? '1 : ((SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1));
        return shifted[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/core_bank_arbiter.sv
// Combinational eligibility check and winner select (fixed priority or
// round-robin starting at ptr_i) across the core bank.
module core_bank_arbiter
    import core_bank_pkg::*;
#(
    parameter int N_CORES  = 33,
    parameter int EN_W     = 4,
    parameter int EN_MATCH = 1,
    parameter int RR_MODE  = 0,
    parameter int IDX_W    = $clog2(N_CORES)
) (
    input  logic [N_CORES*EN_W-1:0] core_out_en_i,
    input  logic [N_CORES-1:0]      core_rst_i,
    input  logic [IDX_W-1:0]        ptr_i,
    output logic [IDX_W-1:0]        win_idx_o,
    output logic                    any_o,
    output logic                    multi_o
);

    logic [BUS_MAX_W-1:0] en_bus_pad;
    logic [N_CORES-1:0]   elig;
    logic [N_CORES-1:0]   upper_mask;
    logic [N_CORES-1:0]   masked;
    logic [IDX_W-1:0]     low_idx;
    logic [IDX_W-1:0]     rr_idx;

    assign en_bus_pad = BUS_MAX_W'(core_out_en_i);

    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_elig
            logic [SLICE_MAX_W-1:0] en_word;
            assign en_word  = extract_slice(en_bus_pad, gi, EN_W);
            // A core still held in reset is never eligible.
            assign elig[gi] = (en_word == SLICE_MAX_W'(EN_MATCH)) && !core_rst_i[gi];
        end
    endgenerate

    // Lowest eligible index overall, and lowest eligible index at or above ptr.
    always_comb begin
        upper_mask = ~((N_CORES'(1) << ptr_i) - N_CORES'(1));
        masked     = elig & upper_mask;
        low_idx    = '0;
        rr_idx     = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (elig[i])   low_idx = IDX_W'(i);
            if (masked[i]) rr_idx  = IDX_W'(i);
        end
        // Round-robin wraps to the lowest eligible index when nothing sits at/above ptr.
        if ((RR_MODE != 0) && (masked != '0)) win_idx_o = rr_idx;
        else                                  win_idx_o = low_idx;
        any_o   = (elig != '0);
        multi_o = ((elig & (elig - N_CORES'(1))) != '0);
    end

endmodule

// File: rtl/core_bank_sequencer.sv
// Staggered per-core reset release plus registered output arbitration
// for a bank of parallel cores sharing one output path.
module core_bank_sequencer
    import core_bank_pkg::*;
#(
    parameter int N_CORES    = 33,
    parameter int STAGGER    = 11,
    parameter int OUT_W      = 28,
    parameter int EN_W       = 4,
    parameter int EN_MATCH   = 1,
    parameter int RR_MODE    = 0,
    parameter int AUTO_START = 1,
    parameter int IDX_W      = $clog2(N_CORES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     restart_i,
    input  logic [N_CORES*OUT_W-1:0] core_io_out_i,
    input  logic [N_CORES*EN_W-1:0]  core_out_en_i,
    output logic [N_CORES-1:0]       core_rst_o,
    output logic signed [OUT_W-1:0]  io_out_o,
    output logic [EN_W-1:0]          out_en_o,
    output logic                     out_valid_o,
    output logic [IDX_W-1:0]         out_idx_o,
    output logic                     collision_o,
    output logic [COLL_CNT_W-1:0]    collision_cnt_o,
    output logic                     seq_done_o
);

    localparam int                CNT_W    = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_CORES - 1);

    seq_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [N_CORES-1:0]      core_rst_q;
    logic                    seq_done_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        ptr_d;
    logic signed [OUT_W-1:0] io_out_q;
    logic [EN_W-1:0]         out_en_q;
    logic                    out_valid_q;
    logic [IDX_W-1:0]        out_idx_q;
    logic                    collision_q;
    logic [COLL_CNT_W-1:0]   coll_cnt_q;

    logic [IDX_W-1:0]        win_idx;
    logic                    win_any;
    logic                    win_multi;
    logic                    restart_fire;

    // Restart is ignored while idle; it also beats a simultaneous start.
    assign restart_fire = restart_i && (state_q != IDLE);
    assign ptr_d        = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;

    core_bank_arbiter #(
        .N_CORES  (N_CORES),
        .EN_W     (EN_W),
        .EN_MATCH (EN_MATCH),
        .RR_MODE  (RR_MODE),
        .IDX_W    (IDX_W)
    ) u_arbiter (
        .core_out_en_i (core_out_en_i),
        .core_rst_i    (core_rst_q),
        .ptr_i         (ptr_q),
        .win_idx_o     (win_idx),
        .any_o         (win_any),
        .multi_o       (win_multi)
    );

    // Release sequencer: drop one core reset every STAGGER cycles, then hold in RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= (AUTO_START != 0) ? RELEASE : IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            core_rst_q <= '1;
            seq_done_q <= 1'b0;
        end else if (restart_fire) begin
            state_q    <= RELEASE;
            cnt_q      <= '0;
            idx_q      <= '0;
            core_rst_q <= '1;
            seq_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                RELEASE: begin
                    if (cnt_q == '0) core_rst_q[idx_q] <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q    <= RUN;
                            seq_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register the arbitration winner, collision flag/count and RR pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_out_q    <= '0;
            out_en_q    <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
            ptr_q       <= '0;
        end else begin
            if (win_any) begin
                io_out_q    <= core_io_out_i[win_idx*OUT_W +: OUT_W];
                out_en_q    <= core_out_en_i[win_idx*EN_W +: EN_W];
                out_valid_q <= 1'b1;
                out_idx_q   <= win_idx;
            end else begin
                io_out_q    <= '0;
                out_en_q    <= '0;
                out_valid_q <= 1'b0;
                out_idx_q   <= '0;
            end
            collision_q <= win_multi;
            if (win_multi && (coll_cnt_q != '1)) coll_cnt_q <= coll_cnt_q + 1'b1;
            if (restart_fire)  ptr_q <= '0;
            else if (win_any)  ptr_q <= ptr_d;
        end
    end

    assign core_rst_o      = core_rst_q;
    assign seq_done_o      = seq_done_q;
    assign io_out_o        = io_out_q;
    assign out_en_o        = out_en_q;
    assign out_valid_o     = out_valid_q;
    assign out_idx_o       = out_idx_q;
    assign collision_o     = collision_q;
    assign collision_cnt_o = coll_cnt_q;

endmodule

// File: tb/tb_core_bank_sequencer.sv
// Bench for core_bank_sequencer: a fixed-priority and a round-robin instance
// share all inputs; a reference model pushes expectations to a scoreboard.
`timescale 1ns/1ps
module tb_core_bank_sequencer;

    localparam int N  = 4;
    localparam int S  = 3;
    localparam int OW = 28;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          restart = 1'b0;
    logic [N*OW-1:0] io_bus = '0;
    logic [N*EW-1:0] en_bus = '0;

    logic [N-1:0]  f_core_rst, r_core_rst;
    logic [OW-1:0] f_io, r_io;
    logic [EW-1:0] f_en, r_en;
    logic          f_valid, r_valid;
    logic [1:0]    f_idx, r_idx;
    logic          f_coll, r_coll;
    logic [15:0]   f_ccnt, r_ccnt;
    logic          f_done, r_done;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_edge = 0;
    int m_ptr  = 0;
    int m_ccnt = 0;

    typedef struct {
        logic [N-1:0]  core_rst;
        logic          seq_done;
        logic          f_valid;
        logic [1:0]    f_idx;
        logic [OW-1:0] f_io;
        logic [EW-1:0] f_en;
        logic          r_valid;
        logic [1:0]    r_idx;
        logic [OW-1:0] r_io;
        logic [EW-1:0] r_en;
        logic          coll;
        logic [15:0]   ccnt;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [N-1:0][EW-1:0] en;
        logic [N-1:0][OW-1:0] d;
        logic                 valid;
        logic [1:0]           idx;
        logic [OW-1:0]        io;
        logic                 coll;
        logic [15:0]          ccnt;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    core_bank_sequencer #(
        .N_CORES(N), .STAGGER(S), .OUT_W(OW), .EN_W(EW), .EN_MATCH(1),
        .RR_MODE(0), .AUTO_START(1)
    ) u_fixed (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .restart_i(restart),
        .core_io_out_i(io_bus), .core_out_en_i(en_bus),
        .core_rst_o(f_core_rst), .io_out_o(f_io), .out_en_o(f_en),
        .out_valid_o(f_valid), .out_idx_o(f_idx), .collision_o(f_coll),
        .collision_cnt_o(f_ccnt), .seq_done_o(f_done)
    );

    core_bank_sequencer #(
        .N_CORES(N), .STAGGER(S), .OUT_W(OW), .EN_W(EW), .EN_MATCH(1),
        .RR_MODE(1), .AUTO_START(1)
    ) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .restart_i(restart),
        .core_io_out_i(io_bus), .core_out_en_i(en_bus),
        .core_rst_o(r_core_rst), .io_out_o(r_io), .out_en_o(r_en),
        .out_valid_o(r_valid), .out_idx_o(r_idx), .collision_o(r_coll),
        .collision_cnt_o(r_ccnt), .seq_done_o(r_done)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected core_rst when e edges have elapsed since the sequence started.
    function automatic logic [N-1:0] rst_at(input int e);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (e < 1 + k * S);
        return r;
    endfunction

    task automatic set_core(input int k, input logic [EW-1:0] en, input logic [OW-1:0] d);
        en_bus[k*EW +: EW] = en;
        io_bus[k*OW +: OW] = d;
    endtask

    task automatic clear_cores();
        en_bus = '0;
        io_bus = '0;
    endtask

    // One clock: model predicts, pushes, then pops and compares after the edge.
    task automatic step(input string tag, input bit do_check);
        exp_t         e;
        logic [N-1:0] pre_rst;
        logic [N-1:0] elig;
        int           fw, rw, k;
        pre_rst = rst_at(m_edge);
        for (int i = 0; i < N; i++)
            elig[i] = (en_bus[i*EW +: EW] == 4'd1) && !pre_rst[i];
        fw = -1;
        for (int i = 0; i < N; i++) if (elig[i] && fw < 0) fw = i;
        rw = -1;
        for (int j = 0; j < N; j++) begin
            k = (m_ptr + j) % N;
            if (elig[k] && rw < 0) rw = k;
        end
        e.coll = ($countones(elig) > 1);
        if (e.coll && m_ccnt < 65535) m_ccnt++;
        e.ccnt    = 16'(m_ccnt);
        e.f_valid = (fw >= 0);
        e.f_idx   = '0; e.f_io = '0; e.f_en = '0;
        if (fw >= 0) begin
            e.f_idx = 2'(fw); e.f_io = io_bus[fw*OW +: OW]; e.f_en = en_bus[fw*EW +: EW];
        end
        e.r_valid = (rw >= 0);
        e.r_idx   = '0; e.r_io = '0; e.r_en = '0;
        if (rw >= 0) begin
            e.r_idx = 2'(rw); e.r_io = io_bus[rw*OW +: OW]; e.r_en = en_bus[rw*EW +: EW];
        end
        if (restart) begin
            m_edge = 0;
            m_ptr  = 0;
        end else begin
            m_edge++;
            if (rw >= 0) m_ptr = (rw + 1) % N;
        end
        e.core_rst = rst_at(m_edge);
        e.seq_done = (m_edge >= N * S);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (do_check) begin
            chk({tag, ".core_rst"}, 64'(f_core_rst), 64'(e.core_rst));
            chk({tag, ".rr_core_rst"}, 64'(r_core_rst), 64'(e.core_rst));
            chk({tag, ".seq_done"}, 64'(f_done), 64'(e.seq_done));
            chk({tag, ".f_valid"}, 64'(f_valid), 64'(e.f_valid));
            chk({tag, ".f_idx"}, 64'(f_idx), 64'(e.f_idx));
            chk({tag, ".f_io"}, 64'(f_io), 64'(e.f_io));
            chk({tag, ".f_en"}, 64'(f_en), 64'(e.f_en));
            chk({tag, ".r_valid"}, 64'(r_valid), 64'(e.r_valid));
            chk({tag, ".r_idx"}, 64'(r_idx), 64'(e.r_idx));
            chk({tag, ".r_io"}, 64'(r_io), 64'(e.r_io));
            chk({tag, ".r_en"}, 64'(r_en), 64'(e.r_en));
            chk({tag, ".collision"}, 64'(f_coll), 64'(e.coll));
            chk({tag, ".rr_collision"}, 64'(r_coll), 64'(e.coll));
            chk({tag, ".ccnt"}, 64'(f_ccnt), 64'(e.ccnt));
            chk({tag, ".rr_ccnt"}, 64'(r_ccnt), 64'(e.ccnt));
            $display("[%0t] %s rst=%b done=%0b fix(v=%0b i=%0d io=%0h) rr(v=%0b i=%0d io=%0h) coll=%0b cnt=%0d",
                     $time, tag, f_core_rst, f_done, f_valid, f_idx, f_io,
                     r_valid, r_idx, r_io, f_coll, f_ccnt);
        end
    endtask

    // Full release sequence; gate=1 drives the reset-gating/match-value pattern.
    task automatic run_release(input string tag, input bit gate);
        for (int e = 1; e <= N * S; e++) begin
            clear_cores();
            if (gate && e <= 10) begin
                set_core(3, 4'd1, 28'd77);
                set_core(0, 4'd2, 28'd55);
            end
            step($sformatf("%s_e%0d", tag, e), 1'b1);
            case (e)
                1:  chk({tag, ".rst_edge1"},  64'(f_core_rst), 64'(4'b1110));
                4:  chk({tag, ".rst_edge4"},  64'(f_core_rst), 64'(4'b1100));
                7:  chk({tag, ".rst_edge7"},  64'(f_core_rst), 64'(4'b1000));
                10: chk({tag, ".rst_edge10"}, 64'(f_core_rst), 64'(4'b0000));
                11: chk({tag, ".done_edge11"}, 64'(f_done), 64'(1'b0));
                12: chk({tag, ".done_edge12"}, 64'(f_done), 64'(1'b1));
                default: ;
            endcase
            if (gate && e <= 10) begin
                chk({tag, ".gate_valid"}, 64'(f_valid), 64'(1'b0));
                chk({tag, ".gate_io"},    64'(f_io),    64'(0));
                chk({tag, ".gate_en"},    64'(f_en),    64'(0));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".core_rst"}, 64'(f_core_rst), 64'(4'b1111));
        chk({tag, ".rr_core_rst"}, 64'(r_core_rst), 64'(4'b1111));
        chk({tag, ".io_out"}, 64'(f_io), 64'(0));
        chk({tag, ".out_en"}, 64'(f_en), 64'(0));
        chk({tag, ".out_valid"}, 64'(f_valid), 64'(0));
        chk({tag, ".rr_out_valid"}, 64'(r_valid), 64'(0));
        chk({tag, ".out_idx"}, 64'(f_idx), 64'(0));
        chk({tag, ".collision"}, 64'(f_coll), 64'(0));
        chk({tag, ".ccnt"}, 64'(f_ccnt), 64'(0));
        chk({tag, ".rr_ccnt"}, 64'(r_ccnt), 64'(0));
        chk({tag, ".seq_done"}, 64'(f_done), 64'(0));
        $display("[%0t] %s reset values rst=%b valid=%0b cnt=%0d done=%0b",
                 $time, tag, f_core_rst, f_valid, f_ccnt, f_done);
    endtask

    int rr_exp[6] = '{0, 2, 3, 0, 2, 3};

    initial begin
        // Fixed-priority vectors applied in RUN (hand-derived expectations).
        for (int i = 0; i < 7; i++) begin
            vecs[i].en = '0;
            vecs[i].d  = '0;
        end
        vecs[0].en[1] = 4'd1; vecs[0].d[1] = 28'd100; vecs[0].en[3] = 4'd1; vecs[0].d[3] = -28'sd5;
        vecs[0].valid = 1; vecs[0].idx = 2'd1; vecs[0].io = 28'd100; vecs[0].coll = 1; vecs[0].ccnt = 16'd1;
        vecs[1].en[2] = 4'd1; vecs[1].d[2] = 28'd7;
        vecs[1].valid = 1; vecs[1].idx = 2'd2; vecs[1].io = 28'd7; vecs[1].coll = 0; vecs[1].ccnt = 16'd1;
        vecs[2].d[0] = 28'd9;
        vecs[2].valid = 0; vecs[2].idx = 2'd0; vecs[2].io = 28'd0; vecs[2].coll = 0; vecs[2].ccnt = 16'd1;
        for (int k = 0; k < N; k++) begin
            vecs[3].en[k] = 4'd1; vecs[3].d[k] = 28'(k + 1);
        end
        vecs[3].valid = 1; vecs[3].idx = 2'd0; vecs[3].io = 28'd1; vecs[3].coll = 1; vecs[3].ccnt = 16'd2;
        vecs[4].en[3] = 4'd1; vecs[4].d[3] = 28'hFFFFFFF; vecs[4].en[0] = 4'd3; vecs[4].d[0] = 28'd11;
        vecs[4].valid = 1; vecs[4].idx = 2'd3; vecs[4].io = 28'hFFFFFFF; vecs[4].coll = 0; vecs[4].ccnt = 16'd2;
        vecs[5].en[0] = 4'd1; vecs[5].d[0] = 28'h7FFFFFF; vecs[5].en[1] = 4'd15; vecs[5].d[1] = 28'd3;
        vecs[5].valid = 1; vecs[5].idx = 2'd0; vecs[5].io = 28'h7FFFFFF; vecs[5].coll = 0; vecs[5].ccnt = 16'd2;
        vecs[6].en[1] = 4'd1; vecs[6].d[1] = 28'h8000000; vecs[6].en[2] = 4'd1; vecs[6].d[2] = 28'd2;
        vecs[6].valid = 1; vecs[6].idx = 2'd1; vecs[6].io = 28'h8000000; vecs[6].coll = 1; vecs[6].ccnt = 16'd3;

        // Power-on reset
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Release timing with reset gating / match-value pattern
        run_release("release", 1'b1);

        // Table-driven fixed-priority vectors in RUN
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < N; k++) set_core(k, vecs[i].en[k], vecs[i].d[k]);
            step($sformatf("vec%0d", i), 1'b1);
            chk($sformatf("vec%0d.hand_valid", i), 64'(f_valid), 64'(vecs[i].valid));
            chk($sformatf("vec%0d.hand_idx", i),   64'(f_idx),   64'(vecs[i].idx));
            chk($sformatf("vec%0d.hand_io", i),    64'(f_io),    64'(vecs[i].io));
            chk($sformatf("vec%0d.hand_coll", i),  64'(f_coll),  64'(vecs[i].coll));
            chk($sformatf("vec%0d.hand_ccnt", i),  64'(f_ccnt),  64'(vecs[i].ccnt));
        end

        // Round-robin: park pointer at 0 via a lone grant to core 3, then 0/2/3 continuously
        clear_cores();
        set_core(3, 4'd1, 28'd30);
        step("rr_park", 1'b1);
        set_core(0, 4'd1, 28'd10);
        set_core(2, 4'd1, 28'd20);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("rr%0d", i), 1'b1);
            chk($sformatf("rr%0d.hand_idx", i), 64'(r_idx), 64'(rr_exp[i]));
            chk($sformatf("rr%0d.hand_fix_idx", i), 64'(f_idx), 64'(0));
        end

        // Restart in RUN, then an identical release sequence
        clear_cores();
        restart = 1'b1;
        step("restart", 1'b1);
        restart = 1'b0;
        chk("restart.hand_core_rst", 64'(f_core_rst), 64'(4'b1111));
        chk("restart.hand_seq_done", 64'(f_done), 64'(0));
        chk("restart.hand_ccnt", 64'(f_ccnt), 64'(9));
        run_release("rerelease", 1'b0);

        // Collision saturation
        for (int k = 0; k < N; k++) set_core(k, 4'd1, 28'(k + 40));
        for (int i = 0; i < 70000; i++) step("sat", 1'b0);
        step("sat_final", 1'b1);
        chk("sat.hand_ccnt", 64'(f_ccnt), 64'(16'hFFFF));
        chk("sat.hand_rr_ccnt", 64'(r_ccnt), 64'(16'hFFFF));

        // Async reset mid-RELEASE
        clear_cores();
        set_core(0, 4'd1, 28'd33);
        restart = 1'b1;
        step("pre_async_restart", 1'b1);
        restart = 1'b0;
        for (int i = 0; i < 5; i++) step($sformatf("pre_async%0d", i), 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_values("async");
        m_edge = 0;
        m_ptr  = 0;
        m_ccnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("post_async%0d", i), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
